// File: rtl/pipe_mem_arbiter_if.sv
// Memory-side bus shared by instruction fetch and data access.
// The arbiter is the master; the memory model or controller is the slave.
interface pipe_mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// Shares one variable-latency memory between IF and MEM: stalls the pipeline,
// services the data access and then the fetch, and releases stall for one cycle.
module pipe_mem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   if_addr,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [WIDTH-1:0]   dm_addr,
    input  logic [WIDTH-1:0]   dm_wdata,
    output logic               stall,
    output logic [WIDTH-1:0]   instr,
    output logic [WIDTH-1:0]   rdata,
    output logic               err,
    output logic [1:0]         err_code,
    pipe_mem_arbiter_if.master mem
);
    typedef enum logic [2:0] {IDLE, DATA, FETCH, ADV, ERR} state_t;

    localparam logic [7:0]       LAST_WAIT = 8'(MAX_WAIT - 1);
    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        err_code_d  = err_code_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                // data alignment is checked first so its code wins
                if (dm_req && (dm_addr[1:0] != 2'b00)) begin
                    state_d    = ERR;
                    err_code_d = 2'b10;
                end else if (if_addr[1:0] != 2'b00) begin
                    state_d    = ERR;
                    err_code_d = 2'b11;
                end else begin
                    state_d    = dm_req ? DATA : FETCH;
                    wait_cnt_d = '0;
                end
            end
            DATA: begin
                if (mem.mem_ready) begin
                    if (!dm_we) rdata_d = mem.mem_rdata;
                    state_d    = FETCH;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = ERR;
                    err_code_d = 2'b01;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FETCH: begin
                if (mem.mem_ready) begin
                    instr_d = mem.mem_rdata;
                    state_d = ADV;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = ERR;
                    err_code_d = 2'b01;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ADV:     state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        // bus registers are loaded from the next state so they are stable
        // for the whole request and drop the cycle after mem_ready
        case (state_d)
            DATA: begin
                mem_req_d   = 1'b1;
                mem_we_d    = dm_we;
                mem_addr_d  = dm_addr;
                mem_wdata_d = dm_wdata;
            end
            FETCH: begin
                mem_req_d  = 1'b1;
                mem_addr_d = if_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            instr_q     <= NOP;
            rdata_q     <= '0;
            err_code_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            err_code_q  <= err_code_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign stall         = (state_q != ADV);
    assign err           = (state_q == ERR);
    assign err_code      = err_code_q;
    assign instr         = instr_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Sequencer that shares one single-ported, variable-latency memory between the pipeline's instruction fetch (IF stage) and data access (MEM stage). It freezes the whole pipeline with `stall` while the accesses required for one pipeline step are serviced in order: data first, then fetch. It releases `stall` for exactly one advance cycle with the fetched instruction and load data held stable. It also detects memory timeouts and misaligned addresses and parks the pipeline in a sticky error state.

## Interface
- `WIDTH`, 32: address/data width.
- `MAX_WAIT`, 15: maximum cycles a memory transaction may stay outstanding; legal range 1..255.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `if_addr`  input  WIDTH  fetch address (PCF); stable while `stall`=1.
- `dm_req`  input  1  MEM-stage instruction is a load or store; stable while `stall`=1.
- `dm_we`  input  1  1 = store, 0 = load.
- `dm_addr`  input  WIDTH  data address.
- `dm_wdata`  input  WIDTH  store data.
- `stall`  output  1  1 = hold all pipeline registers; drives StallF, StallD and the E/M/W enables.
- `instr`  output  WIDTH  fetched instruction (InstrF).
- `rdata`  output  WIDTH  load data (ReadData).
- `mem_req`  output  1  memory request valid.
- `mem_we`  output  1  memory write enable.
- `mem_addr`  output  WIDTH  memory address.
- `mem_wdata`  output  WIDTH  memory write data.
- `mem_rdata`  input  WIDTH  memory read data; valid only in the `mem_ready` cycle.
- `mem_ready`  input  1  one-cycle completion pulse; may arrive in the same cycle `mem_req` first rises.
- `err`  output  1  sticky error flag.
- `err_code`  output  2  01 = timeout, 10 = misaligned data address, 11 = misaligned fetch address.

## Operation
- States:
  - IDLE: `stall`=1, `mem_req`=0; sample requests.
    - `dm_req`=1 and `dm_addr[1:0]`≠0 → ERR, code 10.
    - Otherwise `if_addr[1:0]`≠0 → ERR, code 11. The data check has priority.
    - Otherwise `dm_req`=1 → DATA, else → FETCH.
  - DATA: `stall`=1.
    - `mem_req`=1, `mem_addr`=`dm_addr`, `mem_we`=`dm_we`, `mem_wdata`=`dm_wdata`.
    - On `mem_ready`: a load captures `mem_rdata` into `rdata`; a store leaves `rdata` unchanged. Next state FETCH.
  - FETCH: `stall`=1.
    - `mem_req`=1, `mem_addr`=`if_addr`, `mem_we`=0, `mem_wdata`=0.
    - On `mem_ready`: capture `mem_rdata` into `instr`; next state ADV.
  - ADV: `stall`=0 for exactly this one cycle, `mem_req`=0. Next state IDLE.
  - ERR: `stall`=1, `mem_req`=0, `err`=1. Exit only by reset.
- Handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` are held constant from the first `mem_req` cycle until the `mem_ready` cycle.
  - `mem_req` drops in the cycle after `mem_ready`.
  - `mem_ready` while `mem_req`=0 is ignored.
- `instr` and `rdata` are registered. They change only at a capture edge and otherwise hold their values, including through ADV and the following IDLE.
- Timeout:
  - An 8-bit `wait_cnt` clears on entry to DATA/FETCH and increments on each cycle in that state without `mem_ready`.
  - If the MAX_WAIT-th request cycle ends without `mem_ready` → ERR, code 01.
  - `mem_ready` in the MAX_WAIT-th cycle counts as a success: ready wins over timeout.
- `err_code` is written once on entry to ERR and is never overwritten.

## Timing
- Reset values:
  - State IDLE, `stall`=1.
  - `instr`=32'h00000013 (NOP), `rdata`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `err`=0, `err_code`=0, `wait_cnt`=0.
- Reset asserted mid-transaction: reset values appear after the next edge. The outstanding memory request is abandoned, and the memory must tolerate a dropped `mem_req`.
- Step length, with wd/wf = memory wait cycles (0 = ready in the first request cycle):
  - No data access: 3+wf cycles (IDLE, FETCH 1+wf, ADV).
  - With data access: 4+wd+wf cycles.
- The pipeline advances on the single rising edge at the end of the ADV cycle.
- Branch redirects take effect at that edge, so `if_addr` is never changed by the datapath mid-step.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_ready`/`mem_rdata` to `stall`.

## Test plan
- Zero-wait fetch only: `dm_req`=0, `if_addr`=0x100, memory returns 0x00500093 with `mem_ready` in the first request cycle. Required: `stall` pattern 1,1,0 repeating; `instr`=0x00500093 during ADV.
- Load then fetch, 2 wait cycles each: `dm_addr`=0x2000 returns 0xDEADBEEF, fetch at 0x104. Required: data request first; `rdata`=0xDEADBEEF; step length 8 cycles; `mem_addr` stable during each wait.
- Store: `dm_we`=1, `dm_addr`=0x2004, `dm_wdata`=0x12345678. Required: one `mem_we`=1 transaction with those values; `rdata` unchanged; then fetch with `mem_we`=0.
- Timeout: `MAX_WAIT`=4, `mem_ready` never asserted during FETCH. Required: ERR after the 4th request cycle; `err`=1, `err_code`=01; `stall`=1 forever. A second run with `mem_ready` in the 4th cycle must complete normally.
- Misaligned address: `dm_req`=1, `dm_addr`=0x2002. Required: no `mem_req`; ERR with `err_code`=10. With `dm_req`=0 and `if_addr`=0x102: `err_code`=11.
- Reset mid-FETCH: drive `reset`=0 during a wait cycle. Required: after the edge, `mem_req`=0, `stall`=1, `instr`=0x00000013, state IDLE; the next step fetches normally.
